// File: rtl/aes_enc_core.sv
// AES-128 encryption datapath and round sequencer.
// One round per clock against an external key-expansion block and an external
// 16-byte combinational S-box. Block accepted at T, ciphertext valid at T+12.
// Optional build macro: AES_OUT_HOLD_EN (adds out_ready; DONE waits for it).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for plaintext; in_ready high, key_en = in_valid
// RUN   | rnd 0: initial AddRoundKey; rnd 1..ROUND-1 full rounds; ROUND final
// DONE  | ciphertext on cipher_text with out_valid high
`timescale 1ns/1ps

module aes_enc_core #(
   parameter int ROUND = 10
) (
   input  logic             sclk,
   input  logic             srst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0][7:0] plain_text,
   output logic             key_en,
   input  logic [15:0][7:0] round_key,
   output logic [15:0][7:0] sbox_key,
   input  logic [15:0][7:0] sbox_val,
   output logic             out_valid,
`ifdef AES_OUT_HOLD_EN
   input  logic             out_ready,
`endif
   output logic [15:0][7:0] cipher_text
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [3:0] LAST_RND = 4'(ROUND);

   state_e           state_q, state_d;
   logic [3:0]       rnd_q, rnd_d;
   logic [15:0][7:0] st_q, st_d;
   logic [15:0][7:0] sr_val;
   logic [15:0][7:0] mc_val;

   // Byte i of the packed state holds s(r,c) with i = 15 - (4*c + r).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [15:0][7:0] shift_rows(input logic [15:0][7:0] s);
      logic [15:0][7:0] o;
      o = s;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[4'(15 - (4*c + r))] = s[4'(15 - (4*((c + r) % 4) + r))];
         end
      end
      return o;
   endfunction

   function automatic logic [15:0][7:0] mix_columns(input logic [15:0][7:0] s);
      logic [15:0][7:0] o;
      logic [7:0]       a0, a1, a2, a3;
      o = s;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4'(15 - 4*c)];
         a1 = s[4'(14 - 4*c)];
         a2 = s[4'(13 - 4*c)];
         a3 = s[4'(12 - 4*c)];
         o[4'(15 - 4*c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[4'(14 - 4*c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[4'(13 - 4*c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[4'(12 - 4*c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Handshake; ready is masked by reset so nothing is accepted while held.
   assign in_ready    = srst_n & (state_q == S_IDLE);
   assign key_en      = in_valid & in_ready;
   assign out_valid   = (state_q == S_DONE);
   assign cipher_text = out_valid ? st_q : '0;
   assign sbox_key    = st_q;

   // Round datapath: the S-box result of the current state comes straight back.
   assign sr_val = shift_rows(sbox_val);
   assign mc_val = mix_columns(sr_val);

   // Next-state and round sequencing.
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      st_d    = st_q;
      case (state_q)
         S_IDLE: begin
            if (key_en) begin
               st_d    = plain_text;
               rnd_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (rnd_q == 4'd0) begin
               st_d  = st_q ^ round_key;
               rnd_d = 4'd1;
            end else if (rnd_q == LAST_RND) begin
               st_d    = sr_val ^ round_key;
               rnd_d   = '0;
               state_d = S_DONE;
            end else begin
               st_d  = mc_val ^ round_key;
               rnd_d = rnd_q + 4'd1;
            end
         end
         S_DONE: begin
`ifdef AES_OUT_HOLD_EN
            if (out_ready) begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: begin
            state_d = S_IDLE;
            rnd_d   = '0;
            st_d    = '0;
         end
      endcase
   end

   // State, round counter and cipher state registers.
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state_q <= S_IDLE;
         rnd_q   <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         st_q    <= st_d;
      end
   end

endmodule

// File: doc/aes_enc_core.md
AES_ENC_CORE -- requirements
Module: aes_enc_core

Interface
REQ-001 SHALL have parameter: ROUND, 10, number of cipher rounds (AES-128).
REQ-002 SHALL have port: sclk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port: srst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  plaintext offered.
REQ-005 SHALL have port: in_ready  output  1  core idle, can accept plaintext.
REQ-006 SHALL have port: plain_text  input  [7:0] x [15:0]  plaintext; byte 15 = first FIPS byte s(0,0), column-major down to byte 0 = s(3,3).
REQ-007 SHALL have port: key_en  output  1  start pulse to the key-expansion en input.
REQ-008 SHALL have port: round_key  input  [7:0] x [15:0]  current round key from key expansion, same byte order.
REQ-009 SHALL have port: sbox_key  output  [7:0] x [15:0]  bytes to external combinational S-box.
REQ-010 SHALL have port: sbox_val  input  [7:0] x [15:0]  S-box results, same index.
REQ-011 SHALL have port: out_valid  output  1  ciphertext valid.
REQ-012 SHALL have port: out_ready  input  1  ciphertext accepted (present only with AES_OUT_HOLD_EN).
REQ-013 SHALL have port: cipher_text  output  [7:0] x [15:0]  ciphertext, same byte order.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE plus 4-bit round counter rnd and 128-bit state register st.
REQ-015 SHALL drive in_ready = 1 only in IDLE; key_en = in_valid & in_ready (combinational, one cycle).
REQ-016 IDLE, accept (in_valid & in_ready) at cycle T: st <= plain_text, rnd <= 0, -> RUN; key material presented to key expansion SHALL be stable at T.
REQ-017 SHALL drive sbox_key[i] = st byte i in every state.
REQ-018 RUN, rnd==0 (cycle T+1, round_key = initial key): st <= st ^ round_key, rnd <= 1.
REQ-019 RUN, rnd 1..ROUND-1: st <= MixColumns(ShiftRows(sbox_val)) ^ round_key, rnd <= rnd+1.
REQ-020 RUN, rnd==ROUND: st <= ShiftRows(sbox_val) ^ round_key (no MixColumns), -> DONE.
REQ-021 ShiftRows SHALL rotate row r left by r columns; MixColumns SHALL use GF(2^8) matrix {02 03 01 01} circulant, xtime reduction by 0x1B.
REQ-022 SHALL assert out_valid only in DONE; cipher_text = st when out_valid = 1, else 0.
REQ-023 Latency: accept at T -> out_valid first high at T+12.
REQ-024 in_valid SHALL be ignored (no key_en, no state change) outside IDLE.
REQ-025 round_key SHALL be consumed with no skew: round r key used in cycle T+1+r, r = 0..10.

Reset
REQ-026 srst_n low SHALL asynchronously force IDLE, rnd = 0, st = 0; out_valid = 0, cipher_text = 0.
REQ-027 in_ready and key_en SHALL be 0 while srst_n low; in_ready = 1 the first cycle after release.
REQ-028 Reset mid-operation SHALL abandon the block with no output; the next accept starts a fresh encryption.

Configuration
REQ-029 Macro AES_OUT_HOLD_EN defined: out_ready port exists; DONE holds out_valid and cipher_text stable until out_ready = 1, then -> IDLE next cycle; out_ready high in DONE at T+12 gives in_ready at T+13.
REQ-030 Macro AES_OUT_HOLD_EN undefined: no out_ready port; DONE lasts exactly one cycle (out_valid one-cycle pulse at T+12), then IDLE, in_ready at T+13.

Verification (bench instantiates core with key-expansion block and a 16-byte S-box)
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, out_valid at T+12.
REQ-032 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Back-to-back: in_valid held high for two blocks -> second accept at T+13, both cts correct, exactly two key_en pulses.
REQ-034 With AES_OUT_HOLD_EN: out_ready low 5 cycles after out_valid -> out_valid, ct stable, in_ready 0; out_ready high -> in_ready 1 next cycle.
REQ-035 srst_n low during rnd==5 -> out_valid, cipher_text 0 immediately; after release, vector REQ-032 still produces correct ct.
REQ-036 in_valid pulsed during RUN -> no key_en, ct of in-flight block unchanged.
